// File: rtl/s2mm_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s2mm_ctrl_pkg : shared types and constants for the S2MM frame controller
// Rev 1.0
// ----------------------------------------------------------------------------
package s2mm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_CMD      = 3'd3,
    ST_STREAM   = 3'd4,
    ST_CHECK    = 3'd5
  } state_e;

  // err_code bit positions
  localparam int ERR_OVF = 0;
  localparam int ERR_TMO = 1;
  localparam int ERR_CNT = 2;
  localparam int ERR_CFG = 3;

  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_MAX_BUFS   = 4;

endpackage
`default_nettype wire

// File: rtl/s2mm_buf_ring.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s2mm_buf_ring : ring-buffer index and destination address accumulator
// Rev 1.0
// ----------------------------------------------------------------------------
module s2mm_buf_ring #(
  parameter int MAX_BUFS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        advance,
  input  logic [31:0]                 base,
  input  logic [31:0]                 stride,
  input  logic [$clog2(MAX_BUFS):0]   num_bufs,
  output logic [$clog2(MAX_BUFS)-1:0] idx,
  output logic [31:0]                 addr
);

  localparam int IDX_W = $clog2(MAX_BUFS);
  localparam int NUM_W = IDX_W + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic             at_last;

  assign at_last = ({1'b0, idx_q} == (num_bufs - NUM_W'(1)));

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    if (load) begin
      idx_d  = '0;
      addr_d = base;
    end else if (advance) begin
      if (at_last) begin
        idx_d  = '0;
        addr_d = base;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        addr_d = addr_q + stride;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      addr_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
    end
  end

  assign idx  = idx_q;
  assign addr = addr_q;

endmodule
`default_nettype wire

// File: rtl/s2mm_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// s2mm_frame_ctrl : arms, flushes, commands and checks S2MM frame captures
// Rev 1.0
// ----------------------------------------------------------------------------
module s2mm_frame_ctrl
  import s2mm_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_BUFS   = DEF_MAX_BUFS
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        cfg_arm,
  input  logic                        cfg_stop,
  input  logic                        cfg_continuous,
  input  logic [15:0]                 cfg_line_bytes,
  input  logic [15:0]                 cfg_lines,
  input  logic [31:0]                 cfg_buf_base,
  input  logic [31:0]                 cfg_buf_stride,
  input  logic [$clog2(MAX_BUFS):0]   cfg_num_bufs,
  input  logic [31:0]                 cfg_timeout,
  input  logic                        cam_frame_start,
  output logic                        new_frame,
  output logic [31:0]                 expBytes,
  input  logic [31:0]                 dataCnt,
  input  logic                        FIFO_overflow,
  input  logic                        AxisDataVld,
  input  logic                        AxisDataRead,
  input  logic                        AxisDataEnd,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [31:0]                 cmd_addr,
  output logic [31:0]                 cmd_len,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic [3:0]                  err_code,
  output logic [31:0]                 frame_count,
  output logic [$clog2(MAX_BUFS)-1:0] buf_idx
);

  localparam int IDX_W = $clog2(MAX_BUFS);
  localparam int NUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  state_e           state_q, state_d;
  logic             arm_pend_q, arm_pend_d;
  logic [31:0]      prod_q, prod_d;
  logic             cont_q, cont_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      stride_q, stride_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [31:0]      tmo_cfg_q, tmo_cfg_d;
  logic [31:0]      exp_q, exp_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             new_frame_q, new_frame_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [31:0]      idle_q, idle_d;
  logic             tmo_hit_q, tmo_hit_d;
  logic             ovf_meta_q, ovf_meta_d;
  logic             ovf_sync_q, ovf_sync_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [3:0]       err_code_q, err_code_d;
  logic [31:0]      fcount_q, fcount_d;

  logic             beat;
  logic             last;
  logic             cfg_bad;
  logic [3:0]       err_vec;
  logic             ring_load;
  logic             ring_adv;
  logic [31:0]      ring_addr;
  logic [IDX_W-1:0] ring_idx;

  assign beat    = AxisDataVld & AxisDataRead;
  assign last    = beat & AxisDataEnd;
  assign cfg_bad = (prod_q == 32'd0) || (prod_q[1:0] != 2'b00) ||
                   (num_q == '0) || (num_q > NUM_W'(MAX_BUFS));

  always_comb begin
    state_d     = state_q;
    arm_pend_d  = arm_pend_q;
    prod_d      = prod_q;
    cont_d      = cont_q;
    base_d      = base_q;
    stride_d    = stride_q;
    num_d       = num_q;
    tmo_cfg_d   = tmo_cfg_q;
    exp_d       = exp_q;
    flush_cnt_d = flush_cnt_q;
    new_frame_d = new_frame_q;
    cmd_valid_d = cmd_valid_q;
    idle_d      = idle_q;
    tmo_hit_d   = tmo_hit_q;
    err_code_d  = err_code_q;
    fcount_d    = fcount_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ring_load   = 1'b0;
    ring_adv    = 1'b0;
    ovf_meta_d  = FIFO_overflow;
    ovf_sync_d  = ovf_meta_q;
    ovf_d       = ovf_q | ovf_sync_q;

    err_vec          = '0;
    err_vec[ERR_OVF] = ovf_q;
    err_vec[ERR_TMO] = tmo_hit_q;
    err_vec[ERR_CNT] = (dataCnt != exp_q);

    case (state_q)
      ST_IDLE: begin
        // Config is latched on the arm cycle and judged one cycle later,
        // once the registered line*lines product is available.
        if (arm_pend_q) begin
          arm_pend_d = 1'b0;
          if (cfg_bad) begin
            err_d      = 1'b1;
            err_code_d = 4'b0001 << ERR_CFG;
          end else begin
            exp_d      = prod_q;
            err_code_d = '0;
            ring_load  = 1'b1;
            state_d    = ST_WAIT_SOF;
          end
        end else if (cfg_arm) begin
          arm_pend_d = 1'b1;
          prod_d     = 32'(cfg_line_bytes) * 32'(cfg_lines);
          cont_d     = cfg_continuous;
          base_d     = cfg_buf_base;
          stride_d   = cfg_buf_stride;
          num_d      = cfg_num_bufs;
          tmo_cfg_d  = cfg_timeout;
        end
      end

      ST_WAIT_SOF: begin
        if (cfg_stop) begin
          state_d = ST_IDLE;
        end else if (cam_frame_start) begin
          new_frame_d = 1'b1;
          flush_cnt_d = CNT_W'(1);
          state_d     = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (cfg_stop) cont_d = 1'b0;
        if (flush_cnt_q == CNT_W'(RST_CYCLES)) begin
          new_frame_d = 1'b0;
          ovf_d       = 1'b0;
          cmd_valid_d = 1'b1;
          state_d     = ST_CMD;
        end else begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end

      ST_CMD: begin
        if (cfg_stop) cont_d = 1'b0;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          err_code_d  = '0;
          idle_d      = '0;
          tmo_hit_d   = 1'b0;
          state_d     = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (cfg_stop) cont_d = 1'b0;
        if (last) begin
          idle_d  = '0;
          state_d = ST_CHECK;
        end else if (beat) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 32'd1;
          if ((tmo_cfg_q != 32'd0) && (idle_q + 32'd1 == tmo_cfg_q)) begin
            tmo_hit_d = 1'b1;
            state_d   = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        err_code_d = err_vec;
        if (|err_vec) begin
          err_d = 1'b1;
        end else begin
          done_d   = 1'b1;
          fcount_d = fcount_q + 32'd1;
          ring_adv = 1'b1;
        end
        state_d = (cont_q && !cfg_stop) ? ST_WAIT_SOF : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      arm_pend_q  <= 1'b0;
      prod_q      <= '0;
      cont_q      <= 1'b0;
      base_q      <= '0;
      stride_q    <= '0;
      num_q       <= '0;
      tmo_cfg_q   <= '0;
      exp_q       <= '0;
      flush_cnt_q <= '0;
      new_frame_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      idle_q      <= '0;
      tmo_hit_q   <= 1'b0;
      ovf_meta_q  <= 1'b0;
      ovf_sync_q  <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      fcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      arm_pend_q  <= arm_pend_d;
      prod_q      <= prod_d;
      cont_q      <= cont_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      num_q       <= num_d;
      tmo_cfg_q   <= tmo_cfg_d;
      exp_q       <= exp_d;
      flush_cnt_q <= flush_cnt_d;
      new_frame_q <= new_frame_d;
      cmd_valid_q <= cmd_valid_d;
      idle_q      <= idle_d;
      tmo_hit_q   <= tmo_hit_d;
      ovf_meta_q  <= ovf_meta_d;
      ovf_sync_q  <= ovf_sync_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      fcount_q    <= fcount_d;
    end
  end

  s2mm_buf_ring #(
    .MAX_BUFS (MAX_BUFS)
  ) u_ring (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (ring_load),
    .advance  (ring_adv),
    .base     (base_q),
    .stride   (stride_q),
    .num_bufs (num_q),
    .idx      (ring_idx),
    .addr     (ring_addr)
  );

  assign new_frame   = new_frame_q;
  assign expBytes    = exp_q;
  assign cmd_len     = exp_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_addr    = ring_addr;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;
  assign frame_count = fcount_q;
  assign buf_idx     = ring_idx;

endmodule
`default_nettype wire

// File: tb/tb_s2mm_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_s2mm_frame_ctrl : vector table, hand sequences and random frames
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_s2mm_frame_ctrl;

  localparam int RST_CYCLES = 16;
  localparam int MAX_BUFS   = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_arm = 1'b0, cfg_stop = 1'b0, cfg_continuous = 1'b0;
  logic [15:0] cfg_line_bytes = '0, cfg_lines = '0;
  logic [31:0] cfg_buf_base = '0, cfg_buf_stride = '0, cfg_timeout = '0;
  logic [2:0]  cfg_num_bufs = '0;
  logic        cam_frame_start = 1'b0;
  logic        new_frame;
  logic [31:0] expBytes;
  logic [31:0] dataCnt = '0;
  logic        FIFO_overflow = 1'b0;
  logic        AxisDataVld = 1'b0, AxisDataRead = 1'b0, AxisDataEnd = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr, cmd_len;
  logic        busy, frame_done, frame_err;
  logic [3:0]  err_code;
  logic [31:0] frame_count;
  logic [1:0]  buf_idx;

  always #5 sys_clk = ~sys_clk;

  s2mm_frame_ctrl #(.RST_CYCLES(RST_CYCLES), .MAX_BUFS(MAX_BUFS)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
    .cfg_continuous(cfg_continuous), .cfg_line_bytes(cfg_line_bytes), .cfg_lines(cfg_lines),
    .cfg_buf_base(cfg_buf_base), .cfg_buf_stride(cfg_buf_stride), .cfg_num_bufs(cfg_num_bufs),
    .cfg_timeout(cfg_timeout), .cam_frame_start(cam_frame_start), .new_frame(new_frame),
    .expBytes(expBytes), .dataCnt(dataCnt), .FIFO_overflow(FIFO_overflow),
    .AxisDataVld(AxisDataVld), .AxisDataRead(AxisDataRead), .AxisDataEnd(AxisDataEnd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .frame_count(frame_count), .buf_idx(buf_idx)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ring position is plain modular arithmetic on an index.
  int unsigned m_fc, m_idx, m_nbufs, m_tmo;
  logic [31:0] m_base, m_stride, m_len;
  bit          m_cont;
  logic [31:0] last_addr;

  typedef struct {
    int lb; int lines; int nbufs; int tmo; int nbeats;
    bit last; int cnt_off; bit ovf; int rdy; logic [3:0] exp_err;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_new_frame"}, new_frame, 0);
    chk({p, "_expBytes"}, expBytes, 0);
    chk({p, "_cmd_valid"}, cmd_valid, 0);
    chk({p, "_cmd_addr"}, cmd_addr, 0);
    chk({p, "_cmd_len"}, cmd_len, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_pulses"}, {frame_done, frame_err}, 0);
    chk({p, "_err_code"}, err_code, 0);
    chk({p, "_frame_count"}, frame_count, 0);
    chk({p, "_buf_idx"}, buf_idx, 0);
  endtask

  task automatic arm(input int lb, input int lines, input int nbufs, input logic [31:0] base,
                     input logic [31:0] stride, input bit cont, input int tmo, input bit exp_bad);
    @(negedge sys_clk);
    cfg_line_bytes = 16'(lb); cfg_lines = 16'(lines); cfg_num_bufs = 3'(nbufs);
    cfg_buf_base = base; cfg_buf_stride = stride; cfg_continuous = cont; cfg_timeout = tmo;
    cfg_arm = 1'b1;
    @(negedge sys_clk);
    cfg_arm = 1'b0;
    @(negedge sys_clk);
    chk("arm_busy", busy, !exp_bad);
    chk("arm_err_pulse", frame_err, exp_bad);
    chk("arm_err_code", err_code, exp_bad ? 32'd8 : 32'd0);
    if (exp_bad) begin
      @(negedge sys_clk);
      chk("cfg_err_one_cycle", frame_err, 0);
      chk("cfg_err_idle", busy, 0);
    end else begin
      m_len = 32'(lb * lines); m_base = base; m_stride = stride; m_nbufs = nbufs;
      m_cont = cont; m_tmo = tmo; m_idx = 0;
      chk("arm_expBytes", expBytes, m_len);
      chk("arm_buf_idx", buf_idx, 0);
    end
  endtask

  task automatic run_frame(input int nbeats, input bit last, input logic [31:0] cnt, input bit ovf,
                           input int rdy, input bit stop, input bit gaps, input logic [3:0] exp_err);
    logic [31:0] exp_addr;
    int n, lat, bound, exp_lat;
    bit seen;
    exp_addr = m_base + 32'(m_idx) * m_stride;
    cam_frame_start = 1'b1;
    @(negedge sys_clk);
    cam_frame_start = 1'b0;
    n = 0;
    while (new_frame && n < 100) begin n++; @(negedge sys_clk); end
    chk("new_frame_width", n, RST_CYCLES);
    chk("cmd_valid_start", cmd_valid, 1);
    chk("cmd_addr", cmd_addr, exp_addr);
    chk("cmd_len", cmd_len, m_len);
    chk("expBytes", expBytes, m_len);
    last_addr = cmd_addr;
    for (int i = 0; i < rdy; i++) begin
      @(negedge sys_clk);
      chk("cmd_valid_hold", cmd_valid, 1);
      chk("cmd_addr_hold", cmd_addr, exp_addr);
    end
    cmd_ready = 1'b1;
    @(negedge sys_clk);
    cmd_ready = 1'b0;
    chk("cmd_accept", cmd_valid, 0);
    chk("err_code_clear", err_code, 0);
    dataCnt = cnt;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        AxisDataVld = 1'b1; AxisDataRead = 1'b0; AxisDataEnd = 1'b0;
        FIFO_overflow = 1'b0; cfg_stop = 1'b0;
        @(negedge sys_clk);
      end
      AxisDataVld = 1'b1; AxisDataRead = 1'b1;
      AxisDataEnd = last && (i == nbeats - 1);
      FIFO_overflow = ovf && (i == 0);
      cfg_stop = stop && (i == 1);
      if (i < nbeats - 1) @(negedge sys_clk);
    end
    exp_lat = last ? 2 : int'(m_tmo) + 2;
    bound = exp_lat + 10;
    seen = 0; lat = 0;
    for (int k = 1; k <= bound && !seen; k++) begin
      @(negedge sys_clk);
      AxisDataVld = 1'b0; AxisDataRead = 1'b0; AxisDataEnd = 1'b0;
      FIFO_overflow = 1'b0; cfg_stop = 1'b0;
      if (frame_done || frame_err) begin seen = 1; lat = k; end
    end
    chk("result_seen", seen, 1);
    chk("result_latency", lat, exp_lat);
    chk("frame_done", frame_done, exp_err == 4'd0);
    chk("frame_err", frame_err, exp_err != 4'd0);
    chk("err_code", err_code, exp_err);
    if (exp_err == 4'd0) begin
      m_fc++;
      m_idx = (m_idx + 1) % m_nbufs;
    end
    if (stop) m_cont = 0;
    chk("frame_count", frame_count, m_fc);
    chk("buf_idx", buf_idx, m_idx);
    chk("busy_after", busy, m_cont);
    @(negedge sys_clk);
    chk("pulse_one_cycle", frame_done | frame_err, 0);
    chk("err_code_held", err_code, exp_err);
  endtask

  initial begin
    int n;
    logic [31:0] cont_addr[4];
    logic [31:0] rep_addr;

    //          lb  lines bufs tmo beats last off  ovf rdy err
    tbl[0]  = '{64,  4,   2,   0,  64,  1,   0,   0,  0,  4'h0};
    tbl[1]  = '{64,  4,   2,   0,  16,  1,   0,   1,  0,  4'h1};
    tbl[2]  = '{32,  8,   4,   0,  16,  1,  -4,   0,  3,  4'h4};
    tbl[3]  = '{40,  2,   1, 100,  10,  0,   0,   0,  2,  4'h2};
    tbl[4]  = '{40,  2,   1,  30,   8,  0,  -8,   0,  0,  4'h6};
    tbl[5]  = '{100, 3,   4,   0,  10,  1,   0,   1, 20,  4'h1};
    tbl[6]  = '{64,  0,   2,   0,   4,  1,   0,   0,  0,  4'h8};
    tbl[7]  = '{6,   1,   2,   0,   4,  1,   0,   0,  0,  4'h8};
    tbl[8]  = '{16,  4,   0,   0,   4,  1,   0,   0,  0,  4'h8};
    tbl[9]  = '{16,  4,   5,   0,   4,  1,   0,   0,  0,  4'h8};
    tbl[10] = '{2,   2,   3,   0,   4,  1,   0,   0,  1,  4'h0};
    tbl[11] = '{12, 12,   4,   0,   5,  1,   4,   1,  0,  4'h5};

    m_fc = 0; m_idx = 0; m_nbufs = 1; m_tmo = 0; m_cont = 0;
    m_base = '0; m_stride = '0; m_len = '0;

    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    sys_rst = 1'b0;

    foreach (tbl[i]) begin
      arm(tbl[i].lb, tbl[i].lines, tbl[i].nbufs, 32'h1000_0000 + 32'(i) * 32'h100,
          32'h400, 1'b0, tbl[i].tmo, tbl[i].exp_err == 4'h8);
      if (tbl[i].exp_err != 4'h8)
        run_frame(tbl[i].nbeats, tbl[i].last, 32'(tbl[i].lb * tbl[i].lines + tbl[i].cnt_off),
                  tbl[i].ovf, tbl[i].rdy, 1'b0, i != 0, tbl[i].exp_err);
    end

    // Continuous ring of three buffers, then an overflow that reuses its buffer
    cont_addr = '{32'h8000_0000, 32'h8000_1000, 32'h8000_2000, 32'h8000_0000};
    arm(64, 4, 3, 32'h8000_0000, 32'h1000, 1'b1, 0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      run_frame(8, 1'b1, 32'd256, 1'b0, f, 1'b0, 1'b0, 4'h0);
      chk("ring_addr_seq", last_addr, cont_addr[f]);
    end
    run_frame(8, 1'b1, 32'd256, 1'b1, 0, 1'b0, 1'b0, 4'h1);
    rep_addr = last_addr;
    chk("ovf_frame_addr", rep_addr, 32'h8000_1000);
    run_frame(8, 1'b1, 32'd256, 1'b0, 0, 1'b1, 1'b0, 4'h0);
    chk("reused_buffer_addr", last_addr, rep_addr);

    // Stop and SOF in the same cycle while waiting for SOF
    arm(64, 4, 2, 32'h3000_0000, 32'h100, 1'b0, 0, 1'b0);
    cfg_stop = 1'b1; cam_frame_start = 1'b1;
    @(negedge sys_clk);
    cfg_stop = 1'b0; cam_frame_start = 1'b0;
    chk("stop_sof_idle", busy, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (new_frame) n++;
      @(negedge sys_clk);
    end
    chk("stop_sof_no_flush", n, 0);

    // Reset while streaming
    arm(64, 4, 2, 32'h2000_0000, 32'h100, 1'b1, 0, 1'b0);
    cam_frame_start = 1'b1;
    @(negedge sys_clk);
    cam_frame_start = 1'b0;
    n = 0;
    while (new_frame && n < 100) begin n++; @(negedge sys_clk); end
    cmd_ready = 1'b1;
    @(negedge sys_clk);
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      AxisDataVld = 1'b1; AxisDataRead = 1'b1;
      @(negedge sys_clk);
    end
    chk("pre_reset_busy", busy, 1);
    sys_rst = 1'b1; AxisDataVld = 1'b0; AxisDataRead = 1'b0;
    @(negedge sys_clk);
    chk_zero("stream_reset");
    sys_rst = 1'b0;
    m_fc = 0;
    arm(64, 4, 2, 32'h2000_0000, 32'h100, 1'b0, 0, 1'b0);
    run_frame(8, 1'b1, 32'd256, 1'b0, 0, 1'b0, 1'b1, 4'h0);

    // Random continuous sessions against the model
    for (int r = 0; r < 4; r++) begin
      int nb, lb, lines, tmo, nf, nbt;
      bit lst, ovf, cbad;
      logic [31:0] base, stride, cnt;
      logic [3:0] e;
      nb = $urandom_range(1, MAX_BUFS);
      lb = 4 * $urandom_range(1, 64);
      lines = $urandom_range(1, 8);
      base = {16'($urandom_range(0, 65535)), 16'h0};
      stride = {20'h0, 4'($urandom_range(1, 15)), 8'h0};
      tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 40) : 0;
      arm(lb, lines, nb, base, stride, 1'b1, tmo, 1'b0);
      nf = $urandom_range(3, 6);
      for (int f = 0; f < nf; f++) begin
        lst  = (tmo == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        ovf  = ($urandom_range(0, 3) == 0);
        cbad = ($urandom_range(0, 3) == 0);
        cnt  = cbad ? m_len + 32'(4 * $urandom_range(1, 3)) : m_len;
        e = '0;
        e[0] = ovf; e[1] = !lst; e[2] = cbad;
        nbt = $urandom_range(4, 20);
        run_frame(nbt, lst, cnt, ovf, $urandom_range(0, 4), f == nf - 1, 1'b1, e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/s2mm_frame_ctrl.md
Name: s2mm_frame_ctrl

Overview:
Sequences S2MM frame captures. On arm, waits for camera frame start, pulses new_frame to flush the S2MM FIFO, drives expBytes, and issues one DMA command per frame. It then monitors the AXIS beat stream to end-of-frame, checks byte count, overflow and idle timeout, and rotates through a ring of frame buffers. Sits in sys_clk between the register file, the S2MM buffer and the DMA command port.

Parameters:
RST_CYCLES, 16, new_frame pulse width in sys_clk cycles (must be ≥1)
MAX_BUFS, 4, maximum ring-buffer depth

Ports:
sys_clk  in  1  system clock; the only clock
sys_rst  in  1  reset; synchronous, active-high
cfg_arm  in  1  pulse; latch config and start capture
cfg_stop  in  1  pulse; stop after current frame
cfg_continuous  in  1  1 = re-arm after each frame
cfg_line_bytes  in  16  bytes per line
cfg_lines  in  16  lines per frame
cfg_buf_base  in  32  address of buffer 0
cfg_buf_stride  in  32  address step between buffers
cfg_num_bufs  in  clog2(MAX_BUFS)+1  ring depth, 1..MAX_BUFS
cfg_timeout  in  32  idle-beat timeout in cycles; 0 disables
cam_frame_start  in  1  frame-start pulse, already in sys_clk
new_frame  out  1  FIFO flush, high RST_CYCLES cycles
expBytes  out  32  expected frame bytes
dataCnt  in  32  bytes forwarded by the buffer
FIFO_overflow  in  1  overflow flag from rx_clk domain (asynchronous)
AxisDataVld / AxisDataRead / AxisDataEnd  in  1 each  stream monitor taps
cmd_valid  out  1  DMA command valid
cmd_ready  in  1  DMA command accept
cmd_addr  out  32  destination address
cmd_len  out  32  transfer length (= expBytes)
busy  out  1  state ≠ IDLE
frame_done  out  1  one-cycle pulse, frame finished with no error
frame_err  out  1  one-cycle pulse, frame or config error
err_code  out  4  [0] overflow, [1] timeout, [2] count mismatch, [3] bad config; held until next frame or arm
frame_count  out  32  successful frames, wraps
buf_idx  out  clog2(MAX_BUFS)  buffer index of current/next frame

Behaviour:
- Reset values: all outputs 0; state IDLE; the address register holds 0. Reset asserted mid-frame aborts immediately. new_frame drops on the next edge. No pulse is issued.
- Beat = AxisDataVld & AxisDataRead. Last = beat & AxisDataEnd.
- FIFO_overflow passes through a 2-flop synchronizer. A sticky ovf flag clears when new_frame deasserts.
- IDLE:
  - cfg_arm computes lb*lines (16x16, registered) and latches cfg_*.
  - Bad config (product 0, product[1:0] ≠ 0, or cfg_num_bufs 0 or > MAX_BUFS) -> frame_err pulse, err_code=4'b1000, stay IDLE.
  - Otherwise expBytes = product, cmd_len = product, addr = base, buf_idx = 0 -> WAIT_SOF.
  - cfg_arm is ignored when not in IDLE.
- WAIT_SOF:
  - cfg_stop -> IDLE; stop has priority over a same-cycle cam_frame_start.
  - cam_frame_start -> FLUSH.
- FLUSH: new_frame = 1 for exactly RST_CYCLES cycles (counter), then -> CMD. SOF at edge t gives new_frame high at t+1..t+RST_CYCLES.
- CMD:
  - cmd_valid = 1 with cmd_addr stable, beginning the cycle after FLUSH ends; held until cmd_ready.
  - Accept -> STREAM and clear err_code. Zero-wait cmd_ready gives one valid cycle.
- STREAM:
  - Idle counter clears on every beat and counts otherwise.
  - Counter reaching cfg_timeout (≠0) -> CHECK with timeout set.
  - Last -> CHECK.
  - cam_frame_start is ignored.
  - cfg_stop is recorded (clears the latched continuous flag) and the frame completes.
- CHECK (1 cycle):
  - err bits: ovf; timeout; dataCnt ≠ expBytes.
  - Any error -> frame_err pulse; buf_idx/address unchanged (buffer reused).
  - No error -> frame_done pulse and frame_count+1. buf_idx+1 and addr += stride, or wrap to 0/base when buf_idx = num_bufs-1.
  - Then -> WAIT_SOF if continuous and no stop recorded, else IDLE.
- Address uses an accumulator; no multiplier on the address path.

Decomposition:
- Package s2mm_ctrl_pkg:
  - state enum (IDLE, WAIT_SOF, FLUSH, CMD, STREAM, CHECK).
  - err_code bit-index constants.
  - default RST_CYCLES/MAX_BUFS.
- One sub-module: s2mm_buf_ring (buf_idx and address accumulator, with load/advance/wrap).
- Synchronizer is inline.

Test Plan:
- Arm lb=64, lines=4, bufs=2, continuous=0, timeout=0. SOF, cmd_ready tied 1, 64 beats, last on beat 64, dataCnt=256 -> new_frame high 16 cycles; cmd_len=256, cmd_addr=base; frame_done; frame_count=1; IDLE.
- Continuous, bufs=3, stride=0x1000, 4 good frames -> cmd_addr base, +0x1000, +0x2000, base; buf_idx 0,1,2,0.
- FIFO_overflow pulse mid-frame, dataCnt=expBytes -> frame_err, err_code=4'b0001; next cmd_addr repeats the same buffer.
- timeout=100, beats stop after 10 -> CHECK 100 cycles after the last beat; err_code=4'b0010 (plus 4'b0100 if dataCnt short).
- Arm lines=0, then lb=6/lines=1 -> each gives frame_err with err_code=4'b1000 and busy stays 0. cfg_stop same cycle as SOF in WAIT_SOF -> IDLE, no new_frame.
- cmd_ready low 20 cycles -> cmd_valid/addr stable throughout. Also assert sys_rst in STREAM -> all outputs 0 next edge.
